layer2_avgpool: RTL and testbench

Downstream stage of the 3x3 convolution / max-pool engine. It reads the 32x32 layer-1 map (13-bit unsigned, 9.4 fixed point) after the engine's busy falls and applies a 2x2, stride-2 average pool with round-half-up. It writes the resulting 16x16 layer-2 map to a dedicated 256-entry result memory. Software/testbench starts it with a one-cycle start strobe and sees a done pulse on completion.

---
 rtl/layer2_avgpool.sv | 155 +++++++++++++++
 tb/tb_layer2_avgpool.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/layer2_avgpool.sv
`default_nettype none
// ============================================================================
// Module      : layer2_avgpool
// Description : 2x2 / stride-2 average pool, 32x32 -> 16x16, 13-bit unsigned
//               9.4 fixed point, round-half-up. Reads the layer-1 map one tap
//               per cycle and writes each pooled value to the layer-2 memory.
// Ports       : clk, reset (async, active-high)
//               start  - one-cycle strobe, accepted only in IDLE
//               busy   - pass in progress
//               done   - one-cycle pulse after the final write
//               rd_en/rd_addr/rd_data - layer-1 read port ({row,col}, 5+5 b)
//               wr_en/wr_addr/wr_data - layer-2 write port ({r,c}, 4+4 b)
// Revision    : 1.0 - initial release
// ============================================================================
module layer2_avgpool (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        rd_en,
    output logic [9:0]  rd_addr,
    input  logic [12:0] rd_data,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [12:0] wr_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] c_LAST_TAP = 3'd4;
    localparam logic [7:0] c_LAST_IDX = 8'd255;

    state_t      r_state,   w_state_nxt;
    logic [2:0]  r_tap,     w_tap_nxt;
    logic [7:0]  r_index,   w_index_nxt;
    logic [14:0] r_acc,     w_acc_nxt;
    logic        r_busy,    w_busy_nxt;
    logic        r_done,    w_done_nxt;
    logic        r_rd_en,   w_rd_en_nxt;
    logic [9:0]  r_rd_addr, w_rd_addr_nxt;
    logic        r_wr_en,   w_wr_en_nxt;
    logic [7:0]  r_wr_addr, w_wr_addr_nxt;
    logic [12:0] r_wr_data, w_wr_data_nxt;

    // Four taps of at most 0x1FFF plus the rounding constant stay below 2^15.
    logic [14:0] w_rounded;
    assign w_rounded = r_acc + 15'd2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_tap     <= 3'd0;
            r_index   <= 8'd0;
            r_acc     <= 15'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= 10'd0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 8'd0;
            r_wr_data <= 13'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_tap     <= w_tap_nxt;
            r_index   <= w_index_nxt;
            r_acc     <= w_acc_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tap_nxt     = r_tap;
        w_index_nxt   = r_index;
        w_acc_nxt     = r_acc;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;       // done is a single-cycle pulse
        w_rd_en_nxt   = r_rd_en;
        w_rd_addr_nxt = r_rd_addr;
        w_wr_en_nxt   = 1'b0;       // only the edge leaving WRITE raises it
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_busy_nxt  = 1'b1;
                    w_index_nxt = 8'd0;
                    w_tap_nxt   = 3'd0;
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                // Data for the tap issued at the previous edge arrives now,
                // so accumulation lags the address issue by one tap.
                if (r_tap == 3'd0) begin
                    w_acc_nxt = 15'd0;
                end else begin
                    w_acc_nxt = r_acc + {2'b00, rd_data};
                end
                if (r_tap == c_LAST_TAP) begin
                    w_rd_en_nxt = 1'b0;
                    w_tap_nxt   = 3'd0;
                    w_state_nxt = ST_WRITE;
                end else begin
                    // tap bit 1 selects the row offset, bit 0 the column offset
                    w_rd_addr_nxt = {r_index[7:4], r_tap[1], r_index[3:0], r_tap[0]};
                    w_rd_en_nxt   = 1'b1;
                    w_tap_nxt     = r_tap + 3'd1;
                end
            end
            ST_WRITE: begin
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = r_index;
                w_wr_data_nxt = w_rounded[14:2];
                if (r_index == c_LAST_IDX) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_index_nxt = r_index + 8'd1;
                    w_state_nxt = ST_READ;
                end
            end
            ST_DONE: begin
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rd_en   = r_rd_en;
    assign rd_addr = r_rd_addr;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_layer2_avgpool.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer2_avgpool
// Description : Self-checking bench for layer2_avgpool. A layer-1 memory model
//               feeds the DUT; expected pooled outputs are queued per pass and
//               compared against each observed write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer2_avgpool;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic [12:0] rd_data;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [12:0] wr_data;

    logic [12:0] mem [1024];
    logic [12:0] got [256];
    int unsigned sbq [$];
    int unsigned rdq [$];
    bit          rd_cap;

    int n_checks;
    int n_errors;

    layer2_avgpool u_dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    assign rd_data = mem[rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference pooled value for output index i, from the memory model.
    function automatic int unsigned model_out(input int i);
        int r, c, a, sum;
        r   = i / 16;
        c   = i % 16;
        a   = (2 * r) * 32 + 2 * c;
        sum = int'(mem[a]) + int'(mem[a + 1]) + int'(mem[a + 32]) + int'(mem[a + 33]);
        return (sum + 2) / 4;
    endfunction

    task automatic push_expected();
        for (int i = 0; i < 256; i++) sbq.push_back((i << 16) | model_out(i));
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en) begin
                if (sbq.size() == 0) begin
                    chk("spurious_wr_en", {31'd0, wr_en}, 32'd0);
                end else begin
                    int unsigned e;
                    e = sbq.pop_front();
                    chk("wr_addr", {24'd0, wr_addr}, e >> 16);
                    chk("wr_data", {19'd0, wr_data}, e & 32'hFFFF);
                    got[wr_addr] = wr_data;
                end
            end
            if (rd_en && rd_cap) rdq.push_back({22'd0, rd_addr});
        end
    end

    // One complete pass started by a single strobe; optional stray starts
    // are injected at busy cycles 10 and 800.
    task automatic run_pass(input bit poke);
        int cyc;
        push_expected();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 3000) begin
            cyc++;
            start = poke && (cyc == 10 || cyc == 800);
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_cycles", cyc, 32'd1537);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("rd_addr_end", {22'd0, rd_addr}, 32'h3FF);
        chk("wr_addr_end", {24'd0, wr_addr}, 32'hFF);
        @(negedge clk);
        chk("done_clear", {31'd0, done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("sb_empty", sbq.size(), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"},    {31'd0, busy},    32'd0);
        chk({tag, "_done"},    {31'd0, done},    32'd0);
        chk({tag, "_rd_en"},   {31'd0, rd_en},   32'd0);
        chk({tag, "_rd_addr"}, {22'd0, rd_addr}, 32'd0);
        chk({tag, "_wr_en"},   {31'd0, wr_en},   32'd0);
        chk({tag, "_wr_addr"}, {24'd0, wr_addr}, 32'd0);
        chk({tag, "_wr_data"}, {19'd0, wr_data}, 32'd0);
    endtask

    // Rounding corner cases on output 0: taps at addresses 0,1,32,33.
    logic [12:0] rnd_taps [4][4] = '{
        '{13'd2,      13'd0,      13'd0,      13'd0},
        '{13'd1,      13'd0,      13'd0,      13'd0},
        '{13'd1,      13'd1,      13'd1,      13'd0},
        '{13'h1FFF,   13'h1FFF,   13'h1FFF,   13'h1FFF}
    };
    logic [12:0] rnd_exp [4] = '{13'd1, 13'd0, 13'd1, 13'h1FFF};

    initial begin
        int cyc;
        n_checks = 0;
        n_errors = 0;
        rd_cap   = 1'b0;
        reset    = 1'b1;
        start    = 1'b0;
        for (int a = 0; a < 1024; a++) mem[a] = 13'd0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Constant map, stray starts ignored while busy
        for (int a = 0; a < 1024; a++) mem[a] = 13'h010;
        run_pass(1'b1);
        chk("const_out0", {19'd0, got[0]}, 32'h010);
        chk("const_out200", {19'd0, got[200]}, 32'h010);

        // Ramp map and read-address ordering
        for (int a = 0; a < 1024; a++) mem[a] = a[12:0];
        rdq.delete();
        rd_cap = 1'b1;
        run_pass(1'b0);
        rd_cap = 1'b0;
        chk("rd_count", rdq.size(), 32'd1024);
        if (rdq.size() >= 8) begin
            chk("rd_seq1_0", rdq[4], 32'd2);
            chk("rd_seq1_1", rdq[5], 32'd3);
            chk("rd_seq1_2", rdq[6], 32'd34);
            chk("rd_seq1_3", rdq[7], 32'd35);
        end
        chk("ramp_out0", {19'd0, got[0]}, 32'd17);
        chk("ramp_out255", {19'd0, got[255]}, 32'd1007);

        // Rounding corners
        for (int t = 0; t < 4; t++) begin
            for (int a = 0; a < 1024; a++) mem[a] = 13'd0;
            mem[0]  = rnd_taps[t][0];
            mem[1]  = rnd_taps[t][1];
            mem[32] = rnd_taps[t][2];
            mem[33] = rnd_taps[t][3];
            run_pass(1'b0);
            chk($sformatf("round_case%0d", t), {19'd0, got[0]}, {19'd0, rnd_exp[t]});
        end

        // Start held high: second pass begins right after done
        for (int a = 0; a < 1024; a++) mem[a] = 13'((a * 7 + 3) % 8192);
        push_expected();
        push_expected();
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (busy === 1'b1 && cyc < 3000) begin cyc++; @(negedge clk); end
        chk("held_busy1", cyc, 32'd1537);
        chk("held_done1", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("held_restart_busy", {31'd0, busy}, 32'd1);
        chk("held_restart_done", {31'd0, done}, 32'd0);
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 3000) begin cyc++; @(negedge clk); end
        chk("held_busy2", cyc, 32'd1537);
        @(negedge clk);
        chk("held_sb_empty", sbq.size(), 32'd0);
        chk("held_no_third", {31'd0, busy}, 32'd0);

        // Reset mid-pass
        push_expected();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (699) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_idle_outputs("midreset");
        sbq.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("post_reset_busy", {31'd0, busy}, 32'd0);
        chk("post_reset_wr_addr", {24'd0, wr_addr}, 32'd0);
        run_pass(1'b0);
        chk("post_reset_out0", {19'd0, got[0]}, {19'd0, 13'(model_out(0))});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
